dmi_host_seq: RTL and testbench

- Debugger-side DMI initiator; the other end of the Debug Module register set (data0, abstractcs, command).
- Takes single host requests and turns them into DMI register transactions: raw register read/write, or abstract GPR read/write.
- An abstract access is a full sequence: issue command, poll abstractcs.busy, check and clear cmderr, fetch data0.
- Sits between the host link (UART/JTAG front-end) and the DM's DMI port.

---
 rtl/dmi_host_seq_if.sv | 41 ++++
 rtl/dmi_host_seq.sv | 180 ++++++++++++++++++
 tb/tb_dmi_host_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dmi_host_seq_if.sv
// rtl/dmi_host_seq_if.sv - host request/response and DMI request/response bundle
interface dmi_host_seq_if #(
  parameter int ABITS = 8
);
  // host link
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [ABITS-1:0] req_addr;
  logic [15:0]      req_regno;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rdata;
  logic [2:0]       rsp_err;
  logic             rsp_timeout;
  // DMI port
  logic             dmi_req_valid;
  logic             dmi_req_ready;
  logic             dmi_req_write;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0]      dmi_req_data;
  logic             dmi_rsp_valid;
  logic [31:0]      dmi_rsp_data;

  // sequencer view: serves the host, masters the DMI
  modport master (
    input  req_valid, req_op, req_addr, req_regno, req_wdata, rsp_ready,
    input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_data
  );

  // environment view: host plus debug module
  modport slave (
    output req_valid, req_op, req_addr, req_regno, req_wdata, rsp_ready,
    output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  dmi_req_valid, dmi_req_write, dmi_req_addr, dmi_req_data
  );
endinterface

// File: rtl/dmi_host_seq.sv
// rtl/dmi_host_seq.sv - debugger-side DMI initiator for raw and abstract GPR accesses
module dmi_host_seq #(
  parameter int ABITS      = 8,
  parameter int POLL_LIMIT = 255
) (
  input logic            clk,
  input logic            nRST,
  dmi_host_seq_if.master bus
);
  localparam int CLOG = $clog2(POLL_LIMIT + 1);
  localparam int CW   = (CLOG > 8) ? CLOG : 8;

  localparam logic [ABITS-1:0] A_DATA0 = ABITS'(8'h04);
  localparam logic [ABITS-1:0] A_ACS   = ABITS'(8'h16);
  localparam logic [ABITS-1:0] A_CMD   = ABITS'(8'h17);

  typedef enum logic [2:0] {
    S_IDLE, S_RAW, S_WR_DATA0, S_WR_CMD, S_POLL, S_CLR_ERR, S_RD_DATA0, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             phase_q, phase_d;   // 0: request phase, 1: waiting for response
  logic [1:0]       op_q, op_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [15:0]      regno_q, regno_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       err_q, err_d;
  logic             tmo_q, tmo_d;

  logic             in_tx, tx_write, tx_done;
  logic [ABITS-1:0] tx_addr;
  logic [31:0]      tx_data;

  // state and captured-request registers; reset abandons any sequence
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      regno_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      regno_q <= regno_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // per-state DMI transaction contents
  always_comb begin
    in_tx    = 1'b1;
    tx_write = 1'b0;
    tx_addr  = '0;
    tx_data  = '0;
    case (state_q)
      S_RAW: begin
        tx_write = (op_q == 2'd1);
        tx_addr  = addr_q;
        tx_data  = (op_q == 2'd1) ? wdata_q : 32'h0;
      end
      S_WR_DATA0: begin
        tx_write = 1'b1;
        tx_addr  = A_DATA0;
        tx_data  = wdata_q;
      end
      S_WR_CMD: begin
        tx_write = 1'b1;
        tx_addr  = A_CMD;
        tx_data  = ((op_q == 2'd3) ? 32'h0023_0000 : 32'h0022_0000) | {16'h0, regno_q};
      end
      S_POLL:     tx_addr = A_ACS;
      S_CLR_ERR: begin
        tx_write = 1'b1;
        tx_addr  = A_ACS;
        tx_data  = 32'h0000_0700;
      end
      S_RD_DATA0: tx_addr = A_DATA0;
      default:    in_tx = 1'b0;
    endcase
    tx_done = in_tx && phase_q && bus.dmi_rsp_valid;
  end

  // sequencing: request capture, TX handshake, abstract-command flow, response hold
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    op_d    = op_q;
    addr_d  = addr_q;
    regno_d = regno_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    if (in_tx && !phase_q && bus.dmi_req_ready) phase_d = 1'b1;
    if (tx_done) phase_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        phase_d = 1'b0;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          regno_d = bus.req_regno;
          wdata_d = bus.req_wdata;
          case (bus.req_op)
            2'd2:    state_d = S_WR_CMD;
            2'd3:    state_d = S_WR_DATA0;
            default: state_d = S_RAW;
          endcase
        end
      end
      S_RAW: if (tx_done) begin
        rdata_d = (op_q == 2'd0) ? bus.dmi_rsp_data : 32'h0;
        state_d = S_RESP;
      end
      S_WR_DATA0: if (tx_done) state_d = S_WR_CMD;
      S_WR_CMD: if (tx_done) begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: if (tx_done) begin
        if (bus.dmi_rsp_data[12]) begin
          if (cnt_q == CW'(POLL_LIMIT)) begin
            tmo_d   = 1'b1;
            err_d   = 3'd7;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (bus.dmi_rsp_data[10:8] != 3'd0) begin
          err_d   = bus.dmi_rsp_data[10:8];
          state_d = S_CLR_ERR;
        end else begin
          state_d = (op_q == 2'd2) ? S_RD_DATA0 : S_RESP;
        end
      end
      S_CLR_ERR: if (tx_done) begin
        rdata_d = 32'h0;
        state_d = S_RESP;
      end
      S_RD_DATA0: if (tx_done) begin
        rdata_d = bus.dmi_rsp_data;
        state_d = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) begin
        rdata_d = '0;
        err_d   = '0;
        tmo_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;
  assign bus.rsp_timeout   = tmo_q;
  assign bus.dmi_req_valid = in_tx && !phase_q;
  assign bus.dmi_req_write = (in_tx && !phase_q) ? tx_write : 1'b0;
  assign bus.dmi_req_addr  = (in_tx && !phase_q) ? tx_addr : '0;
  assign bus.dmi_req_data  = (in_tx && !phase_q) ? tx_data : 32'h0;
endmodule

// File: tb/tb_dmi_host_seq.sv
// tb/tb_dmi_host_seq.sv - directed self-checking bench for dmi_host_seq
module tb_dmi_host_seq;
  logic clk = 1'b0;
  logic nRST;
  int   ntot  = 0;
  int   nfail = 0;
  int   cyc   = 0;
  int   t_acc;

  dmi_host_seq_if #(.ABITS(8)) bus ();

  dmi_host_seq #(.ABITS(8), .POLL_LIMIT(3)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_send(input logic [1:0] op, input logic [7:0] addr,
                           input logic [15:0] regno, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_regno = regno;
    bus.req_wdata = wdata;
    chk("req_ready_at_send", {31'h0, bus.req_ready}, 32'h1);
    t_acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("req_ready_drop", {31'h0, bus.req_ready}, 32'h0);
  endtask

  task automatic dmi_tx(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int stall);
    bit found = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.dmi_req_valid === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_seen"}, {31'h0, found}, 32'h1);
    for (int s = 0; s <= stall; s++) begin
      chk({tag, "_wr"},   {31'h0, bus.dmi_req_write}, {31'h0, wr});
      chk({tag, "_addr"}, {24'h0, bus.dmi_req_addr}, {24'h0, addr});
      chk({tag, "_data"}, bus.dmi_req_data, data);
      if (s < stall) begin
        @(negedge clk);
        chk({tag, "_held"}, {31'h0, bus.dmi_req_valid}, 32'h1);
      end
    end
    bus.dmi_req_ready = 1'b1;
    @(negedge clk);
    bus.dmi_req_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'h0, bus.dmi_req_valid}, 32'h0);
    bus.dmi_rsp_valid = 1'b1;
    bus.dmi_rsp_data  = rdata;
    @(negedge clk);
    bus.dmi_rsp_valid = 1'b0;
    bus.dmi_rsp_data  = 32'h0;
  endtask

  task automatic rsp_check(input string tag, input logic [31:0] rdata,
                           input logic [2:0] err, input logic tmo);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_rsp_seen"}, {31'h0, found}, 32'h1);
    chk({tag, "_rdata"}, bus.rsp_rdata, rdata);
    chk({tag, "_err"}, {29'h0, bus.rsp_err}, {29'h0, err});
    chk({tag, "_tmo"}, {31'h0, bus.rsp_timeout}, {31'h0, tmo});
    chk({tag, "_no_req_ready"}, {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    chk({tag, "_rsp_hold"}, {31'h0, bus.rsp_valid}, 32'h1);
    chk({tag, "_rdata_hold"}, bus.rsp_rdata, rdata);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, {31'h0, bus.rsp_valid}, 32'h0);
    chk({tag, "_cleared"}, {bus.rsp_rdata[27:0], bus.rsp_err, bus.rsp_timeout}, 32'h0);
    chk({tag, "_idle"}, {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    nRST              = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_op        = 2'd0;
    bus.req_addr      = 8'h0;
    bus.req_regno     = 16'h0;
    bus.req_wdata     = 32'h0;
    bus.rsp_ready     = 1'b0;
    bus.dmi_req_ready = 1'b0;
    bus.dmi_rsp_valid = 1'b0;
    bus.dmi_rsp_data  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_dmi_valid", {31'h0, bus.dmi_req_valid}, 32'h0);
    nRST = 1'b1;
    @(negedge clk);

    // stray DMI response while idle is ignored
    bus.dmi_rsp_valid = 1'b1;
    bus.dmi_rsp_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.dmi_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_idle", {31'h0, bus.req_ready}, 32'h1);
    chk("stray_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);

    // raw read 0x11
    host_send(2'd0, 8'h11, 16'h0, 32'h0);
    dmi_tx("raw_rd", 1'b0, 8'h11, 32'h0, 32'h0040_0C82, 0);
    chk("raw_latency", cyc - t_acc, 32'd3);
    rsp_check("raw_rd", 32'h0040_0C82, 3'd0, 1'b0);

    // abstract read 0x1005, busy on first poll (stalled request on second poll)
    host_send(2'd2, 8'h0, 16'h1005, 32'h0);
    dmi_tx("ard_cmd", 1'b1, 8'h17, 32'h0022_1005, 32'h0, 0);
    dmi_tx("ard_poll1", 1'b0, 8'h16, 32'h0, 32'h0000_1000, 0);
    dmi_tx("ard_poll2", 1'b0, 8'h16, 32'h0, 32'h0000_0000, 2);
    dmi_tx("ard_data0", 1'b0, 8'h04, 32'h0, 32'hDEAD_BEEF, 0);
    rsp_check("ard", 32'hDEAD_BEEF, 3'd0, 1'b0);

    // abstract write 0x1001
    host_send(2'd3, 8'h0, 16'h1001, 32'h1234_5678);
    dmi_tx("awr_data0", 1'b1, 8'h04, 32'h1234_5678, 32'h0, 0);
    dmi_tx("awr_cmd", 1'b1, 8'h17, 32'h0023_1001, 32'h0, 0);
    dmi_tx("awr_poll", 1'b0, 8'h16, 32'h0, 32'h0, 0);
    rsp_check("awr", 32'h0, 3'd0, 1'b0);

    // abstract read with cmderr=2: clear, no data0 read
    host_send(2'd2, 8'h0, 16'h1000, 32'h0);
    dmi_tx("err_cmd", 1'b1, 8'h17, 32'h0022_1000, 32'h0, 0);
    dmi_tx("err_poll", 1'b0, 8'h16, 32'h0, 32'h0000_0200, 0);
    dmi_tx("err_clr", 1'b1, 8'h16, 32'h0000_0700, 32'h0, 0);
    rsp_check("err", 32'h0, 3'd2, 1'b0);

    // busy stuck: POLL_LIMIT=3 gives four abstractcs reads then timeout
    host_send(2'd2, 8'h0, 16'h1002, 32'h0);
    dmi_tx("tmo_cmd", 1'b1, 8'h17, 32'h0022_1002, 32'h0, 0);
    dmi_tx("tmo_poll0", 1'b0, 8'h16, 32'h0, 32'h0000_1000, 0);
    dmi_tx("tmo_poll1", 1'b0, 8'h16, 32'h0, 32'h0000_1000, 0);
    dmi_tx("tmo_poll2", 1'b0, 8'h16, 32'h0, 32'h0000_1000, 0);
    dmi_tx("tmo_poll3", 1'b0, 8'h16, 32'h0, 32'h0000_1000, 0);
    rsp_check("tmo", 32'h0, 3'd7, 1'b1);

    // stall 5 cycles mid-POLL, then reset
    host_send(2'd2, 8'h0, 16'h1003, 32'h0);
    dmi_tx("rst_cmd", 1'b1, 8'h17, 32'h0022_1003, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'h0, bus.dmi_req_valid}, 32'h1);
      chk("stall_addr", {24'h0, bus.dmi_req_addr}, 32'h16);
      chk("stall_wr", {31'h0, bus.dmi_req_write}, 32'h0);
      @(negedge clk);
    end
    nRST = 1'b0;
    #1;
    chk("mid_rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("mid_rst_dmi_valid", {31'h0, bus.dmi_req_valid}, 32'h0);
    chk("mid_rst_dmi_addr", {24'h0, bus.dmi_req_addr}, 32'h0);
    chk("mid_rst_rsp", {bus.rsp_rdata[27:0], bus.rsp_err, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    // raw write after reset
    host_send(2'd1, 8'h10, 16'h0, 32'h0000_0005);
    dmi_tx("raw_wr", 1'b1, 8'h10, 32'h0000_0005, 32'hAAAA_5555, 0);
    rsp_check("raw_wr", 32'h0, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end
endmodule
